// File: rtl/score_mem_arbiter_pkg.sv
// Shared types and helpers for the score memory arbiter: FSM state encoding,
// requester identifiers and round-robin index arithmetic.
package score_mem_arbiter_pkg;

   localparam int PKG_ADDR_W = 16;
   localparam int PKG_DATA_W = 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } state_t;

   localparam logic [1:0] REQ_UART = 2'd0;
   localparam logic [1:0] REQ_PLAY = 2'd1;
   localparam logic [1:0] REQ_REC  = 2'd2;
   localparam logic [1:0] REQ_NONE = 2'd3;

   // Next requester in round-robin order, wrapping 2 -> 0.
   function automatic logic [1:0] rr_next(input logic [1:0] id);
      logic [1:0] nxt;
      nxt = (id >= REQ_REC) ? REQ_UART : id + 2'd1;
      return nxt;
   endfunction

   function automatic logic [2:0] id_onehot(input logic [1:0] id);
      logic [2:0] oh;
      case (id)
         REQ_UART: oh = 3'b001;
         REQ_PLAY: oh = 3'b010;
         REQ_REC:  oh = 3'b100;
         default:  oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/score_mem_arbiter_if.sv
// Requester and memory-side signal bundle for the score memory arbiter.
// Handshake: each req is a level held until its one-cycle ack pulse; the
// arbiter samples req/addr/wdata only while idle and captures them at grant.
interface score_mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 12
);
   logic              uart_req;
   logic [ADDR_W-1:0] uart_addr;
   logic [DATA_W-1:0] uart_wdata;
   logic              uart_ack;

   logic              play_req;
   logic [ADDR_W-1:0] play_addr;
   logic [DATA_W-1:0] play_rdata;
   logic              play_ack;
   logic              play_block;

   logic              rec_req;
   logic [ADDR_W-1:0] rec_addr;
   logic [DATA_W-1:0] rec_wdata;
   logic              rec_ack;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;
   logic [1:0]        grant_id;

   modport slave (
      input  uart_req, uart_addr, uart_wdata,
      input  play_req, play_addr, play_block,
      input  rec_req, rec_addr, rec_wdata,
      input  mem_rdata,
      output uart_ack, play_ack, play_rdata, rec_ack,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output busy, grant_id
   );

   modport master (
      output uart_req, uart_addr, uart_wdata,
      output play_req, play_addr, play_block,
      output rec_req, rec_addr, rec_wdata,
      output mem_rdata,
      input  uart_ack, play_ack, play_rdata, rec_ack,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  busy, grant_id
   );

endinterface

// File: rtl/score_mem_arbiter_rr_pick3.sv
// Combinational three-way round-robin picker: the first eligible requester
// found starting at the pointer wins.
module score_mem_arbiter_rr_pick3
   import score_mem_arbiter_pkg::*;
(
   input  logic [2:0] i_elig,
   input  logic [1:0] i_ptr,
   output logic [1:0] o_id,
   output logic       o_valid
);

   logic [1:0] w_p0;
   logic [1:0] w_p1;
   logic [1:0] w_p2;

   // A pointer of 3 cannot occur; treat it as 0 so the search stays in range.
   assign w_p0 = (i_ptr == REQ_NONE) ? REQ_UART : i_ptr;
   assign w_p1 = rr_next(w_p0);
   assign w_p2 = rr_next(w_p1);

   always_comb begin
      o_id    = REQ_NONE;
      o_valid = |i_elig;
      // Lowest priority first so the highest-priority hit is the final assignment.
      if (i_elig[w_p2]) o_id = w_p2;
      if (i_elig[w_p1]) o_id = w_p1;
      if (i_elig[w_p0]) o_id = w_p0;
   end

endmodule

// File: rtl/score_mem_arbiter.sv
// Round-robin arbiter sharing one single-port score memory between the UART
// loader, playback reader and recorder; one access per four cycles.
module score_mem_arbiter
   import score_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = PKG_ADDR_W,
   parameter int DATA_W = PKG_DATA_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   score_mem_arbiter_if.slave   io_bus,
   output state_t               o_dbg_state
);

   state_t            r_state;
   logic [1:0]        r_rr_ptr;
   logic [1:0]        r_grant;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_play_rdata;
   logic [2:0]        r_ack;
   logic              r_busy;

   state_t            w_state;
   logic [1:0]        w_rr_ptr;
   logic [1:0]        w_grant;
   logic              w_mem_en;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;
   logic [DATA_W-1:0] w_play_rdata;
   logic [2:0]        w_ack;
   logic              w_busy;

   logic [2:0]        w_elig;
   logic [1:0]        w_pick_id;
   logic              w_pick_valid;

   assign w_elig = {io_bus.rec_req,
                    io_bus.play_req & ~io_bus.play_block,
                    io_bus.uart_req};

   score_mem_arbiter_rr_pick3 u_pick (
      .i_elig  (w_elig),
      .i_ptr   (r_rr_ptr),
      .o_id    (w_pick_id),
      .o_valid (w_pick_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_rr_ptr     <= REQ_UART;
         r_grant      <= REQ_NONE;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_play_rdata <= '0;
         r_ack        <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_rr_ptr     <= w_rr_ptr;
         r_grant      <= w_grant;
         r_mem_en     <= w_mem_en;
         r_mem_we     <= w_mem_we;
         r_mem_addr   <= w_mem_addr;
         r_mem_wdata  <= w_mem_wdata;
         r_play_rdata <= w_play_rdata;
         r_ack        <= w_ack;
         r_busy       <= w_busy;
      end
   end

   always_comb begin
      w_state      = r_state;
      w_rr_ptr     = r_rr_ptr;
      w_grant      = r_grant;
      w_mem_en     = r_mem_en;
      w_mem_we     = r_mem_we;
      w_mem_addr   = r_mem_addr;
      w_mem_wdata  = r_mem_wdata;
      w_play_rdata = r_play_rdata;
      w_ack        = r_ack;
      w_busy       = r_busy;

      case (r_state)
         ST_IDLE: begin
            if (w_pick_valid) begin
               w_state  = ST_ISSUE;
               w_grant  = w_pick_id;
               w_mem_en = 1'b1;
               w_mem_we = (w_pick_id != REQ_PLAY);
               w_busy   = 1'b1;
               case (w_pick_id)
                  REQ_UART: begin
                     w_mem_addr  = io_bus.uart_addr;
                     w_mem_wdata = io_bus.uart_wdata;
                  end
                  REQ_PLAY: begin
                     w_mem_addr  = io_bus.play_addr;
                     w_mem_wdata = '0;
                  end
                  default: begin
                     w_mem_addr  = io_bus.rec_addr;
                     w_mem_wdata = io_bus.rec_wdata;
                  end
               endcase
            end
         end

         ST_ISSUE: begin
            w_mem_en = 1'b0;
            w_mem_we = 1'b0;
            w_state  = ST_WAIT;
         end

         // Memory read data is valid in this cycle, one after the strobe.
         ST_WAIT: begin
            if (r_grant == REQ_PLAY) begin
               w_play_rdata = io_bus.mem_rdata;
            end
            w_ack   = id_onehot(r_grant);
            w_state = ST_ACK;
         end

         ST_ACK: begin
            w_ack    = '0;
            w_grant  = REQ_NONE;
            w_rr_ptr = rr_next(r_grant);
            w_busy   = 1'b0;
            w_state  = ST_IDLE;
         end

         default: begin
            w_state  = ST_IDLE;
            w_grant  = REQ_NONE;
            w_mem_en = 1'b0;
            w_mem_we = 1'b0;
            w_ack    = '0;
            w_busy   = 1'b0;
         end
      endcase
   end

   assign io_bus.uart_ack   = r_ack[0];
   assign io_bus.play_ack   = r_ack[1];
   assign io_bus.rec_ack    = r_ack[2];
   assign io_bus.play_rdata = r_play_rdata;
   assign io_bus.mem_en     = r_mem_en;
   assign io_bus.mem_we     = r_mem_we;
   assign io_bus.mem_addr   = r_mem_addr;
   assign io_bus.mem_wdata  = r_mem_wdata;
   assign io_bus.busy       = r_busy;
   assign io_bus.grant_id   = r_grant;
   assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_score_mem_arbiter.sv
// Directed bench for score_mem_arbiter: single accesses, round-robin order,
// play masking and asynchronous reset mid-access, against a small memory model.
module tb_score_mem_arbiter;
   import score_mem_arbiter_pkg::*;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   state_t dbg_state;

   int n_chk = 0;
   int n_err = 0;

   logic [1:0] exp_q[$];
   int         exp_cyc_q[$];

   logic [11:0] mem [0:255];
   logic        pre_we = 1'b0;
   logic [7:0]  pre_addr = '0;
   logic [11:0] pre_data = '0;

   int n_acks;
   int seen_ack;

   score_mem_arbiter_if #(.ADDR_W(16), .DATA_W(12)) bus ();

   score_mem_arbiter #(.ADDR_W(16), .DATA_W(12)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .io_bus      (bus),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // Single-port memory model: strobe-cycle write, data out one cycle after a read strobe.
   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr[7:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic handle_ack(input string tag, input int c);
      logic [1:0] id;
      logic [1:0] e_id;
      int         e_c;
      id = bus.uart_ack ? REQ_UART : (bus.play_ack ? REQ_PLAY : REQ_REC);
      chk({tag, "_grant_at_ack"}, 32'(bus.grant_id), 32'(id));
      if (exp_q.size() == 0) begin
         chk({tag, "_extra_ack"}, 32'(id), 32'(REQ_NONE));
      end else begin
         e_id = exp_q.pop_front();
         e_c  = exp_cyc_q.pop_front();
         chk({tag, "_ack_id"}, 32'(id), 32'(e_id));
         chk({tag, "_ack_cycle"}, 32'(c), 32'(e_c));
      end
      if (id == REQ_PLAY) chk({tag, "_play_rdata"}, 32'(bus.play_rdata), 32'h123);
      case (id)
         REQ_UART: bus.uart_req = 1'b0;
         REQ_PLAY: bus.play_req = 1'b0;
         default:  bus.rec_req  = 1'b0;
      endcase
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_mem_en"}, 32'(bus.mem_en), 32'h0);
      chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'h0);
      chk({tag, "_acks"}, 32'({bus.rec_ack, bus.play_ack, bus.uart_ack}), 32'h0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
      chk({tag, "_grant"}, 32'(bus.grant_id), 32'h3);
      chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
   endtask

   initial begin
      bus.uart_req = 0; bus.uart_addr = '0; bus.uart_wdata = '0;
      bus.play_req = 0; bus.play_addr = '0; bus.play_block = 0;
      bus.rec_req  = 0; bus.rec_addr  = '0; bus.rec_wdata  = '0;

      // Reset values
      step(); step(); step();
      chk_idle("rst");
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
      chk("rst_play_rdata", 32'(bus.play_rdata), 32'h0);
      rst_n = 1'b1;
      step();
      chk_idle("post_rst");

      // Single UART write; address change after grant must be ignored
      bus.uart_req = 1; bus.uart_addr = 16'h0005; bus.uart_wdata = 12'hABC;
      step();
      chk("s1_c1_mem_en", 32'(bus.mem_en), 32'h1);
      chk("s1_c1_mem_we", 32'(bus.mem_we), 32'h1);
      chk("s1_c1_mem_addr", 32'(bus.mem_addr), 32'h0005);
      chk("s1_c1_mem_wdata", 32'(bus.mem_wdata), 32'hABC);
      chk("s1_c1_busy", 32'(bus.busy), 32'h1);
      chk("s1_c1_grant", 32'(bus.grant_id), 32'h0);
      chk("s1_c1_state", 32'(dbg_state), 32'(ST_ISSUE));
      bus.uart_addr = 16'h7777; bus.uart_wdata = 12'h000;
      step();
      chk("s1_c2_mem_en", 32'(bus.mem_en), 32'h0);
      chk("s1_c2_uart_ack", 32'(bus.uart_ack), 32'h0);
      chk("s1_c2_busy", 32'(bus.busy), 32'h1);
      chk("s1_c2_mem_written", 32'(mem[8'h05]), 32'hABC);
      step();
      chk("s1_c3_uart_ack", 32'(bus.uart_ack), 32'h1);
      chk("s1_c3_busy", 32'(bus.busy), 32'h1);
      chk("s1_c3_mem_en", 32'(bus.mem_en), 32'h0);
      bus.uart_req = 0;
      step();
      chk_idle("s1_c4");
      chk("s1_no_stray_write", 32'(mem[8'h05]), 32'hABC);

      // Play read from preloaded model memory
      pre_we = 1; pre_addr = 8'h10; pre_data = 12'h123;
      step();
      pre_we = 0;
      bus.play_req = 1; bus.play_addr = 16'h0010;
      step();
      chk("s2_c1_mem_en", 32'(bus.mem_en), 32'h1);
      chk("s2_c1_mem_we", 32'(bus.mem_we), 32'h0);
      chk("s2_c1_mem_addr", 32'(bus.mem_addr), 32'h0010);
      chk("s2_c1_grant", 32'(bus.grant_id), 32'h1);
      step();
      chk("s2_c2_play_ack", 32'(bus.play_ack), 32'h0);
      step();
      chk("s2_c3_play_ack", 32'(bus.play_ack), 32'h1);
      chk("s2_c3_play_rdata", 32'(bus.play_rdata), 32'h123);
      bus.play_req = 0;
      step();
      chk("s2_c4_play_ack", 32'(bus.play_ack), 32'h0);
      chk("s2_c4_play_rdata", 32'(bus.play_rdata), 32'h123);
      step(); step(); step();
      chk("s2_hold_play_rdata", 32'(bus.play_rdata), 32'h123);

      // All three requesters together right after reset
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      bus.uart_req = 1; bus.uart_addr = 16'h0030; bus.uart_wdata = 12'h111;
      bus.play_req = 1; bus.play_addr = 16'h0010;
      bus.rec_req  = 1; bus.rec_addr  = 16'h0040; bus.rec_wdata  = 12'h222;
      exp_q = '{REQ_UART, REQ_PLAY, REQ_REC};
      exp_cyc_q = '{3, 7, 11};
      for (int c = 1; c <= 12; c++) begin
         step();
         n_acks = int'(bus.uart_ack) + int'(bus.play_ack) + int'(bus.rec_ack);
         if (n_acks != 0) begin
            chk("s3_ack_onehot", 32'(n_acks), 32'h1);
            handle_ack("s3", c);
         end
      end
      chk("s3_all_served", 32'(exp_q.size()), 32'h0);
      chk("s3_rec_mem", 32'(mem[8'h40]), 32'h222);
      chk_idle("s3_end");

      // UART and recorder competing; each re-raises one cycle after its ack
      bus.uart_req = 1; bus.rec_req = 1;
      exp_q = '{REQ_UART, REQ_REC, REQ_UART, REQ_REC};
      exp_cyc_q = '{3, 7, 11, 15};
      for (int c = 1; c <= 16; c++) begin
         step();
         if (c < 12) begin
            bus.uart_req = 1'b1;
            bus.rec_req  = 1'b1;
         end
         n_acks = int'(bus.uart_ack) + int'(bus.play_ack) + int'(bus.rec_ack);
         if (n_acks != 0) begin
            chk("s4_ack_onehot", 32'(n_acks), 32'h1);
            handle_ack("s4", c);
         end
      end
      chk("s4_all_served", 32'(exp_q.size()), 32'h0);
      chk_idle("s4_end");

      // Play masked by play_block, then released; block re-raised mid-access
      bus.play_req = 1; bus.play_addr = 16'h0005; bus.play_block = 1;
      seen_ack = 0;
      for (int c = 1; c <= 19; c++) begin
         step();
         if (bus.mem_en || bus.busy) seen_ack++;
      end
      chk("s5_blocked_no_access", 32'(seen_ack), 32'h0);
      step();
      chk("s5_c20_busy", 32'(bus.busy), 32'h0);
      chk("s5_c20_mem_en", 32'(bus.mem_en), 32'h0);
      bus.play_block = 0;
      step();
      chk("s5_c21_mem_en", 32'(bus.mem_en), 32'h1);
      chk("s5_c21_mem_we", 32'(bus.mem_we), 32'h0);
      chk("s5_c21_grant", 32'(bus.grant_id), 32'h1);
      step();
      chk("s5_c22_play_ack", 32'(bus.play_ack), 32'h0);
      bus.play_block = 1;
      step();
      chk("s5_c23_play_ack", 32'(bus.play_ack), 32'h1);
      chk("s5_c23_play_rdata", 32'(bus.play_rdata), 32'hABC);
      bus.play_req = 0; bus.play_block = 0;
      step();
      chk("s5_c24_play_ack", 32'(bus.play_ack), 32'h0);
      chk("s5_c24_play_rdata", 32'(bus.play_rdata), 32'hABC);

      // Asynchronous reset during ISSUE of a UART write
      bus.uart_req = 1; bus.uart_addr = 16'h0020; bus.uart_wdata = 12'h555;
      step();
      chk("s6_c1_mem_en", 32'(bus.mem_en), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle("s6_in_rst");
      chk("s6_in_rst_mem_addr", 32'(bus.mem_addr), 32'h0);
      bus.uart_req = 0;
      step();
      rst_n = 1'b1;
      seen_ack = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (bus.uart_ack || bus.play_ack || bus.rec_ack) seen_ack++;
      end
      chk("s6_no_ack_after_rst", 32'(seen_ack), 32'h0);
      bus.uart_req = 1; bus.uart_addr = 16'h0021; bus.uart_wdata = 12'h321;
      bus.rec_req  = 1; bus.rec_addr  = 16'h0041; bus.rec_wdata  = 12'h654;
      step();
      chk("s6_rr_ptr_reset_grant", 32'(bus.grant_id), 32'h0);
      bus.uart_req = 0; bus.rec_req = 0;
      step(); step();
      chk("s6_uart_ack", 32'(bus.uart_ack), 32'h1);
      step();
      chk_idle("s6_end");
      chk("s6_mem_written", 32'(mem[8'h21]), 32'h321);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
